// File: rtl/mem_ldst_if.sv
// mem_ldst_if: request, bus-beat and completion signals of the load/store unit
interface mem_ldst_if;
  logic opValid, opReady, opStore, opSigned;
  logic [2:0] opMode;
  logic [63:0] opAddr, opWData;
  logic memReq, memWe;
  logic [63:0] memAddr;
  logic [7:0] memByteEn;
  logic [63:0] memWData, memRData;
  logic memAck;
  logic resValid, resFault;
  logic [63:0] resData;
  modport slave(
    input opValid, opStore, opSigned, opMode, opAddr, opWData, memRData, memAck,
    output opReady, memReq, memWe, memAddr, memByteEn, memWData, resValid, resData, resFault
  );
  modport master(
    output opValid, opStore, opSigned, opMode, opAddr, opWData, memRData, memAck,
    input opReady, memReq, memWe, memAddr, memByteEn, memWData, resValid, resData, resFault
  );
endinterface

// File: rtl/mem_ldst.sv
// mem_ldst: load/store unit splitting an unaligned access into one or two 64-bit bus beats
module mem_ldst #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  mem_ldst_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;
  state_t st, nxt;
  logic we, sgn, fault;
  logic [1:0] sz;
  logic [2:0] off;
  logic [60:0] base;
  logic [63:0] wd, lo, res, raw;
  logic [CW-1:0] cnt;
  logic [7:0] bm;
  logic [15:0] be;
  logic [127:0] wsh;
  logic mode_ok, split, fire, ack, to;

  function automatic logic [63:0] extend(input logic [63:0] r, input logic [1:0] s, input logic sg);
    logic [63:0] m;
    logic b;
    m = s == 2'd0 ? 64'hFF : s == 2'd1 ? 64'hFFFF : s == 2'd2 ? 64'hFFFF_FFFF : '1;
    b = sg & (s == 2'd0 ? r[7] : s == 2'd1 ? r[15] : s == 2'd2 ? r[31] : r[63]);
    return (r & m) | ({64{b}} & ~m);
  endfunction

  assign bm = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
  assign be = {8'h00, bm} << off;
  assign wsh = {64'h0, wd} << {off, 3'b000};
  assign split = |be[15:8];
  assign mode_ok = bus.opMode != 3'd0 && bus.opMode <= 3'd4;
  assign fire = bus.opValid && bus.opReady;
  assign ack = bus.memReq && bus.memAck;
  assign to = bus.memReq && !bus.memAck && cnt == CW'(TIMEOUT - 1);
  assign raw = st == REQ2 ? lo | (bus.memRData << (7'd64 - {1'b0, off, 3'b000}))
                          : bus.memRData >> {off, 3'b000};

  assign bus.opReady = reset_n && st == IDLE;
  assign bus.memReq = st == REQ1 || st == REQ2;
  assign bus.memWe = bus.memReq && we;
  assign bus.memAddr = st == REQ1 ? {base, 3'b000} : st == REQ2 ? {base + 61'd1, 3'b000} : '0;
  assign bus.memByteEn = st == REQ1 ? be[7:0] : st == REQ2 ? be[15:8] : '0;
  assign bus.memWData = st == REQ1 ? wsh[63:0] : st == REQ2 ? wsh[127:64] : '0;
  assign bus.resValid = st == DONE;
  assign bus.resData = st == DONE ? res : '0;
  assign bus.resFault = st == DONE && fault;

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else st <= nxt;

  // next state: accept, beat sequencing, timeout and single-cycle completion
  always_comb begin
    nxt = st;
    case (st)
      IDLE: if (fire) nxt = mode_ok ? REQ1 : DONE;
      REQ1: if (ack) nxt = split ? REQ2 : DONE;
            else if (to) nxt = DONE;
      REQ2: if (ack || to) nxt = DONE;
      DONE: nxt = IDLE;
    endcase
  end

  // latched request, wait counter, partial load data and final result
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      we <= 1'b0;
      sgn <= 1'b0;
      sz <= '0;
      off <= '0;
      base <= '0;
      wd <= '0;
      lo <= '0;
      res <= '0;
      fault <= 1'b0;
      cnt <= '0;
    end else if (fire) begin
      we <= bus.opStore;
      sgn <= bus.opSigned;
      sz <= 2'(bus.opMode[1:0] - 2'd1);
      off <= bus.opAddr[2:0];
      base <= bus.opAddr[63:3];
      wd <= bus.opWData;
      lo <= '0;
      res <= '0;
      fault <= !mode_ok;
      cnt <= '0;
    end else if (ack) begin
      cnt <= '0;
      if (st == REQ1 && split) lo <= raw;
      else res <= we ? '0 : extend(raw, sz, sgn);
    end else if (to) begin
      fault <= 1'b1;
      res <= '0;
    end else if (bus.memReq) cnt <= cnt + CW'(1);
endmodule

// File: tb/tb_mem_ldst.sv
// tb_mem_ldst: directed scoreboard bench for the load/store unit (TIMEOUT=4)
module tb_mem_ldst;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_ldst_if bus();
  mem_ldst #(.TIMEOUT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [63:0] data;
    logic fault;
  } exp_t;
  exp_t sb[$];
  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic st, input logic sg, input logic [2:0] md, input logic [63:0] a,
                    input logic [63:0] wd, input logic [63:0] ed, input logic ef, input bit push);
    exp_t e;
    chk("ready", bus.opReady, 1);
    bus.opValid = 1'b1;
    bus.opStore = st;
    bus.opSigned = sg;
    bus.opMode = md;
    bus.opAddr = a;
    bus.opWData = wd;
    e.data = ed;
    e.fault = ef;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.opValid = 1'b0;
    bus.opStore = ~st;
    bus.opSigned = ~sg;
    bus.opMode = 3'b001;
    bus.opAddr = {$urandom, $urandom};
    bus.opWData = {$urandom, $urandom};
  endtask

  task automatic beat(input string tag, input logic w, input logic [63:0] a, input logic [7:0] be,
                      input logic [63:0] wd, input logic [63:0] rd, input int wait_cyc);
    for (int i = 0; i <= wait_cyc; i++) begin
      chk({tag, ".req"}, bus.memReq, 1);
      chk({tag, ".we"}, bus.memWe, w);
      chk({tag, ".addr"}, bus.memAddr, a);
      chk({tag, ".be"}, bus.memByteEn, be);
      chk({tag, ".wdata"}, bus.memWData, wd);
      if (i == wait_cyc) begin
        bus.memAck = 1'b1;
        bus.memRData = rd;
      end
      @(negedge clk);
    end
    bus.memAck = 1'b0;
    bus.memRData = {$urandom, $urandom};
  endtask

  task automatic result(input string tag);
    exp_t e;
    int n = 0;
    while (!bus.resValid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 0);
    chk({tag, ".sb"}, 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".valid"}, bus.resValid, 1);
      chk({tag, ".data"}, bus.resData, e.data);
      chk({tag, ".fault"}, bus.resFault, e.fault);
      chk({tag, ".noreq"}, bus.memReq, 0);
    end
    @(negedge clk);
    chk({tag, ".pulse"}, bus.resValid, 0);
    chk({tag, ".idle"}, bus.opReady, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.opValid = 1'b0;
    bus.opStore = 1'b0;
    bus.opSigned = 1'b0;
    bus.opMode = 3'b000;
    bus.opAddr = '0;
    bus.opWData = '0;
    bus.memAck = 1'b0;
    bus.memRData = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", bus.opReady, 0);
    chk("rst.req", bus.memReq, 0);
    chk("rst.we", bus.memWe, 0);
    chk("rst.addr", bus.memAddr, 0);
    chk("rst.be", bus.memByteEn, 0);
    chk("rst.wdata", bus.memWData, 0);
    chk("rst.valid", bus.resValid, 0);
    chk("rst.data", bus.resData, 0);
    chk("rst.fault", bus.resFault, 0);
    reset_n = 1'b1;
    @(negedge clk);

    bus.memAck = 1'b1;
    @(negedge clk);
    bus.memAck = 1'b0;
    chk("stray_ack.valid", bus.resValid, 0);
    chk("stray_ack.req", bus.memReq, 0);

    op(0, 1, 3'b001, 64'h1003, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    beat("lb", 0, 64'h1000, 8'h08, 64'h0, 64'h0000_0000_8000_0000, 0);
    result("lb");

    op(1, 0, 3'b011, 64'h2006, 64'h1122_3344, 64'h0, 0, 1);
    beat("sd1", 1, 64'h2000, 8'hC0, 64'h3344_0000_0000_0000, 64'hDEAD, 0);
    beat("sd2", 1, 64'h2008, 8'h03, 64'h1122, 64'hBEEF, 0);
    result("sd");

    op(0, 0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h5566_7788_AABB_CCDD, 0, 1);
    beat("lq1", 0, 64'hFFFF_FFFF_FFFF_FFF8, 8'hF0, 64'h0, 64'hAABB_CCDD_1111_1111, 0);
    beat("lq2", 0, 64'h0, 8'h0F, 64'h0, 64'h2222_2222_5566_7788, 0);
    result("lq");

    op(0, 1, 3'b010, 64'h4007, 64'h0, 64'hFFFF_FFFF_FFFF_FE99, 0, 1);
    beat("lw1", 0, 64'h4000, 8'h80, 64'h0, 64'h9900_0000_0000_0000, 0);
    beat("lw2", 0, 64'h4008, 8'h01, 64'h0, 64'h1234_5678_9ABC_DEFE, 0);
    result("lw");

    op(0, 0, 3'b010, 64'h3006, 64'h0, 64'hF00D, 0, 1);
    beat("lwu", 0, 64'h3000, 8'hC0, 64'h0, 64'hF00D_0000_0000_0000, 2);
    result("lwu");

    op(1, 0, 3'b001, 64'h8005, 64'hAB, 64'h0, 0, 1);
    beat("sb", 1, 64'h8000, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 0);
    result("sb");

    op(0, 0, 3'b111, 64'h1000, 64'h0, 64'h0, 1, 1);
    result("bad111");
    op(1, 0, 3'b000, 64'h1000, 64'h5, 64'h0, 1, 1);
    result("bad000");

    op(0, 0, 3'b001, 64'h5000, 64'h0, 64'h0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("to1.req", bus.memReq, 1);
      @(negedge clk);
    end
    result("to1");

    op(0, 0, 3'b010, 64'h6007, 64'h0, 64'h0, 1, 1);
    beat("to2.b1", 0, 64'h6000, 8'h80, 64'h0, 64'hAB00_0000_0000_0000, 0);
    for (int i = 0; i < 4; i++) begin
      chk("to2.req", bus.memReq, 1);
      chk("to2.addr", bus.memAddr, 64'h6008);
      @(negedge clk);
    end
    result("to2");

    op(1, 0, 3'b011, 64'h2006, 64'h1122_3344, 64'h0, 0, 0);
    beat("ab1", 1, 64'h2000, 8'hC0, 64'h3344_0000_0000_0000, 64'h0, 0);
    chk("ab.req2", bus.memReq, 1);
    reset_n = 1'b0;
    #1;
    chk("ab.req", bus.memReq, 0);
    chk("ab.addr", bus.memAddr, 0);
    chk("ab.be", bus.memByteEn, 0);
    chk("ab.ready", bus.opReady, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ab.ready_rel", bus.opReady, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ab.novalid", bus.resValid, 0);
    end

    op(0, 1, 3'b100, 64'h7000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1);
    beat("post", 0, 64'h7000, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    result("post");

    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
